// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: shadow-buffer write/commit port for display_scan_ctrl.
`default_nettype none

interface display_scan_ctrl_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [2:0] wr_addr;
   logic [3:0] wr_data;
   logic       commit;

   modport master (output wr_valid, wr_addr, wr_data, commit, input wr_ready);
   modport slave  (input wr_valid, wr_addr, wr_data, commit, output wr_ready);
endinterface

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 8-digit multiplexed 7-segment scanner with blanking and double-buffered digits.
// Define DISPLAY_SCAN_HEX_EN to decode 10..15 as A-F instead of blank.
`default_nettype none

module display_scan_ctrl #(
   parameter int SHOW_CYC  = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic                clk,
   input  logic                rst_n,
   display_scan_ctrl_if.slave  wr,
   input  logic [7:0]          digit_en,
   input  logic [7:0]          dp_en,
   output logic [7:0]          seg,
   output logic [7:0]          an,
   output logic                frame_start
);

   typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

   localparam logic [19:0] SHOW_LAST  = 20'(SHOW_CYC - 1);
   localparam logic [19:0] BLANK_LAST = 20'(BLANK_CYC - 1);

   state_t      state, state_nx;
   logic [2:0]  idx, idx_nx;
   logic [19:0] cnt, cnt_nx;
   logic        pending, pending_nx;
   logic [3:0]  shadow    [8];
   logic [3:0]  shadow_nx [8];
   logic [3:0]  active    [8];
   logic [3:0]  active_nx [8];
   logic [7:0]  seg_nx, an_nx;
   logic        wrap;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
`ifdef DISPLAY_SCAN_HEX_EN
         4'd10:   s = 7'h08;
         4'd11:   s = 7'h03;
         4'd12:   s = 7'h46;
         4'd13:   s = 7'h21;
         4'd14:   s = 7'h06;
         default: s = 7'h0E;
`else
         default: s = 7'h7F;
`endif
      endcase
      return s;
   endfunction

   assign wr.wr_ready = ~pending;

   always_comb begin
      state_nx   = state;
      idx_nx     = idx;
      cnt_nx     = cnt + 20'd1;
      wrap       = 1'b0;
      pending_nx = pending;
      shadow_nx  = shadow;
      active_nx  = active;
      seg_nx     = 8'hFF;
      an_nx      = 8'hFF;

      case (state)
         ST_BLANK: begin
            if (cnt == BLANK_LAST) begin
               state_nx = ST_SHOW;
               cnt_nx   = 20'd0;
            end
         end
         default: begin
            if (cnt == SHOW_LAST) begin
               state_nx = ST_BLANK;
               cnt_nx   = 20'd0;
               idx_nx   = idx + 3'd1;
               wrap     = (idx == 3'd7);
            end
         end
      endcase

      // A write accepted alongside the commit must land in the copied snapshot.
      if (wr.wr_valid && !pending)
         shadow_nx[wr.wr_addr] = wr.wr_data;
      if (wr.commit && !pending)
         pending_nx = 1'b1;
      if (wrap && pending_nx) begin
         active_nx  = shadow_nx;
         pending_nx = 1'b0;
      end

      // Active never changes on a BLANK->SHOW edge, so the current copy is safe here.
      if (state_nx == ST_SHOW && digit_en[idx_nx]) begin
         an_nx  = ~(8'b1 << idx_nx);
         seg_nx = {~dp_en[idx_nx], decode(active[idx_nx])};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_BLANK;
         idx         <= 3'd0;
         cnt         <= 20'd0;
         pending     <= 1'b0;
         shadow      <= '{default: 4'd0};
         active      <= '{default: 4'd0};
         seg         <= 8'hFF;
         an          <= 8'hFF;
         frame_start <= 1'b0;
      end else begin
         state       <= state_nx;
         idx         <= idx_nx;
         cnt         <= cnt_nx;
         pending     <= pending_nx;
         shadow      <= shadow_nx;
         active      <= active_nx;
         seg         <= seg_nx;
         an          <= an_nx;
         frame_start <= wrap;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed checks of scan timing, commit, masking, decode and async reset.
`default_nettype none

module tb_display_scan_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] den = 8'hFF;
   logic [7:0] dp = 8'h00;
   logic [7:0] seg, an;
   logic       frame_start;
   logic [3:0] act [8];
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;

   display_scan_ctrl_if bus ();

   display_scan_ctrl #(.SHOW_CYC(4), .BLANK_CYC(1)) dut (
      .clk(clk), .rst_n(rst_n), .wr(bus.slave), .digit_en(den), .dp_en(dp),
      .seg(seg), .an(an), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] dec(input logic [3:0] v);
      logic [6:0] t [16];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
`ifdef DISPLAY_SCAN_HEX_EN
            7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`else
            7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`endif
      return t[v];
   endfunction

   // Frame = 8 slots of (1 blank + 4 show) cycles; cycle 0 is the first cycle after reset release.
   function automatic logic [7:0] exp_seg(input int c);
      int s, ph;
      s  = (c % 40) / 5;
      ph = (c % 40) % 5;
      if (ph == 0 || !den[s]) return 8'hFF;
      return {~dp[s], dec(act[s])};
   endfunction

   function automatic logic [7:0] exp_an(input int c);
      int s, ph;
      s  = (c % 40) / 5;
      ph = (c % 40) % 5;
      if (ph == 0 || !den[s]) return 8'hFF;
      return ~(8'b1 << s);
   endfunction

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      bus.wr_valid = 1'b0;
      bus.commit   = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) act[i] = 4'd0;
      rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.wr_valid = 1'b0; bus.commit = 1'b0; bus.wr_addr = 3'd0; bus.wr_data = 4'd0;
      repeat (3) @(negedge clk);
      total++; if (seg !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h exp=ff", seg); end
      total++; if (an !== 8'hFF) begin bad++; $display("FAIL reset_an got=%h exp=ff", an); end
      total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
      total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.wr_ready); end
   endtask

   task automatic test_scan();
      den = 8'hFF; dp = 8'h00;
      do_reset();
      while (cyc <= 80) begin
         total++; if (seg !== exp_seg(cyc)) begin bad++; $display("FAIL scan_seg cyc=%0d got=%h exp=%h", cyc, seg, exp_seg(cyc)); end
         total++; if (an !== exp_an(cyc)) begin bad++; $display("FAIL scan_an cyc=%0d got=%h exp=%h", cyc, an, exp_an(cyc)); end
         total++; if (frame_start !== (cyc % 40 == 0 && cyc > 0)) begin bad++; $display("FAIL scan_fs cyc=%0d got=%b", cyc, frame_start); end
         tick();
      end
   endtask

   task automatic test_commit();
      logic exp_rdy;
      while (cyc <= 160) begin
         bus.wr_valid = (cyc == 88) || (cyc == 95);
         bus.wr_addr  = (cyc == 88) ? 3'd3 : 3'd4;
         bus.wr_data  = (cyc == 88) ? 4'd7 : 4'd9;
         bus.commit   = (cyc == 90);
         if (cyc == 120) act[3] = 4'd7;
         exp_rdy = !(cyc >= 91 && cyc <= 119);
         total++; if (seg !== exp_seg(cyc)) begin bad++; $display("FAIL commit_seg cyc=%0d got=%h exp=%h", cyc, seg, exp_seg(cyc)); end
         total++; if (bus.wr_ready !== exp_rdy) begin bad++; $display("FAIL commit_ready cyc=%0d got=%b exp=%b", cyc, bus.wr_ready, exp_rdy); end
         tick();
      end
      bus.wr_valid = 1'b0; bus.commit = 1'b0;
   endtask

   task automatic test_back_to_back();
      while (cyc <= 240) begin
         bus.wr_valid = (cyc == 199);
         bus.commit   = (cyc == 199);
         bus.wr_addr  = 3'd0;
         bus.wr_data  = 4'd6;
         if (cyc == 200) act[0] = 4'd6;
         total++; if (seg !== exp_seg(cyc)) begin bad++; $display("FAIL b2b_seg cyc=%0d got=%h exp=%h", cyc, seg, exp_seg(cyc)); end
         total++; if (an !== exp_an(cyc)) begin bad++; $display("FAIL b2b_an cyc=%0d got=%h exp=%h", cyc, an, exp_an(cyc)); end
         total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready cyc=%0d got=%b exp=1", cyc, bus.wr_ready); end
         total++; if (frame_start !== (cyc % 40 == 0)) begin bad++; $display("FAIL b2b_fs cyc=%0d got=%b", cyc, frame_start); end
         tick();
      end
      bus.wr_valid = 1'b0; bus.commit = 1'b0;
   endtask

   task automatic test_mask();
      den = 8'h01; dp = 8'h01;
      do_reset();
      while (cyc <= 120) begin
         bus.wr_valid = (cyc == 2); bus.commit = (cyc == 2);
         bus.wr_addr = 3'd0; bus.wr_data = 4'd5;
         if (cyc == 40) act[0] = 4'd5;
         total++; if (seg !== exp_seg(cyc)) begin bad++; $display("FAIL mask_seg cyc=%0d got=%h exp=%h", cyc, seg, exp_seg(cyc)); end
         total++; if (an !== exp_an(cyc)) begin bad++; $display("FAIL mask_an cyc=%0d got=%h exp=%h", cyc, an, exp_an(cyc)); end
         total++; if (frame_start !== (cyc % 40 == 0 && cyc > 0)) begin bad++; $display("FAIL mask_fs cyc=%0d got=%b", cyc, frame_start); end
         if (cyc == 41) begin
            total++; if (seg !== 8'h12 || an !== 8'hFE) begin bad++; $display("FAIL mask_spot got=%h/%h exp=12/fe", seg, an); end
         end
         tick();
      end
      bus.wr_valid = 1'b0; bus.commit = 1'b0;
   endtask

   task automatic test_hex();
      logic [7:0] spot;
`ifdef DISPLAY_SCAN_HEX_EN
      spot = 8'h83;
`else
      spot = 8'hFF;
`endif
      den = 8'hFF; dp = 8'h20;
      do_reset();
      while (cyc <= 80) begin
         bus.wr_valid = (cyc == 1) || (cyc == 2);
         bus.wr_addr  = (cyc == 1) ? 3'd2 : 3'd5;
         bus.wr_data  = (cyc == 1) ? 4'hB : 4'hF;
         bus.commit   = (cyc == 2);
         if (cyc == 40) begin act[2] = 4'hB; act[5] = 4'hF; end
         total++; if (seg !== exp_seg(cyc)) begin bad++; $display("FAIL hex_seg cyc=%0d got=%h exp=%h", cyc, seg, exp_seg(cyc)); end
         if (cyc == 51) begin
            total++; if (seg !== spot) begin bad++; $display("FAIL hex_spot got=%h exp=%h", seg, spot); end
         end
         tick();
      end
      bus.wr_valid = 1'b0; bus.commit = 1'b0;
   endtask

   task automatic test_async_reset();
      while (cyc < 107) begin
         bus.wr_valid = (cyc == 90); bus.commit = (cyc == 90);
         bus.wr_addr = 3'd1; bus.wr_data = 4'd3;
         tick();
      end
      bus.wr_valid = 1'b0; bus.commit = 1'b0;
      total++; if (an !== 8'hDF || bus.wr_ready !== 1'b0) begin bad++; $display("FAIL arst_pre got=%h/%b exp=df/0", an, bus.wr_ready); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (seg !== 8'hFF) begin bad++; $display("FAIL arst_seg got=%h exp=ff", seg); end
      total++; if (an !== 8'hFF) begin bad++; $display("FAIL arst_an got=%h exp=ff", an); end
      total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL arst_fs got=%b exp=0", frame_start); end
      total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b exp=1", bus.wr_ready); end
      @(negedge clk);
      for (int i = 0; i < 8; i++) act[i] = 4'd0;
      rst_n = 1'b1;
      cyc = 0;
      while (cyc <= 50) begin
         total++; if (seg !== exp_seg(cyc)) begin bad++; $display("FAIL arst_scan_seg cyc=%0d got=%h exp=%h", cyc, seg, exp_seg(cyc)); end
         total++; if (an !== exp_an(cyc)) begin bad++; $display("FAIL arst_scan_an cyc=%0d got=%h exp=%h", cyc, an, exp_an(cyc)); end
         total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL arst_scan_ready cyc=%0d got=%b", cyc, bus.wr_ready); end
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) act[i] = 4'd0;
      test_reset();
      test_scan();
      test_commit();
      test_back_to_back();
      test_mask();
      test_hex();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter SHOW_CYC, default 50000: clock cycles a digit is driven per slot, legal range 1..2^20.
REQ-002 SHALL have parameter BLANK_CYC, default 500: clock cycles all digits are off before each SHOW (anti-ghosting), legal range 1..2^16.
REQ-003 SHALL have port clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_valid  input  1  write request into shadow digit buffer.
REQ-006 SHALL have port wr_ready  output  1  shadow buffer accepts writes.
REQ-007 SHALL have port wr_addr  input  3  digit index 0..7.
REQ-008 SHALL have port wr_data  input  4  digit value.
REQ-009 SHALL have port commit  input  1  pulse: request shadow-to-active copy.
REQ-010 SHALL have port digit_en  input  8  per-digit enable, bit i = digit i.
REQ-011 SHALL have port dp_en  input  8  per-digit decimal point, active-high.
REQ-012 SHALL have port seg  output  8  segments, active-low, order dp-g-f-e-d-c-b-a.
REQ-013 SHALL have port an  output  8  digit select, active-low, bit i = digit i.
REQ-014 SHALL have port frame_start  output  1  one-cycle pulse when scan wraps to digit 0.

Function
REQ-015 SHALL hold an 8x4 shadow buffer and an 8x4 active buffer; only the active buffer drives the display.
REQ-016 SHALL write wr_data into shadow[wr_addr] on a clock edge where wr_valid and wr_ready are both high.
REQ-017 SHALL set a pending flag on commit when not pending; commit while pending is ignored.
REQ-018 SHALL drive wr_ready = not pending; a write and a commit in the same accepted cycle SHALL include that write in the commit.
REQ-019 SHALL run FSM states BLANK and SHOW with a 3-bit digit index idx and a slot counter.
REQ-020 BLANK: an = 8'hFF, seg = 8'hFF for BLANK_CYC cycles, then SHOW.
REQ-021 SHOW: for SHOW_CYC cycles, an = ~(1<<idx) if digit_en[idx] else 8'hFF; seg = decode(active[idx]) with seg[7] = ~dp_en[idx], or 8'hFF if digit disabled.
REQ-022 At end of SHOW, idx SHALL increment modulo 8 and the FSM SHALL return to BLANK; disabled digits still consume their full slot.
REQ-023 On the edge where idx wraps 7->0: frame_start high for exactly the following cycle; if pending, active <= shadow and pending cleared on that same edge.
REQ-024 decode SHALL map 0..9 to 8'hC0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (bits 6:0 used, bit 7 from dp).
REQ-025 seg, an, frame_start SHALL be registered outputs; digit_en/dp_en changes take effect one cycle after sampling.
REQ-026 Frame period SHALL be exactly 8*(BLANK_CYC+SHOW_CYC) cycles.

Reset
REQ-027 While rst_n low: state BLANK, idx 0, counter 0, pending 0, shadow and active all 4'd0, an = 8'hFF, seg = 8'hFF, frame_start 0, wr_ready 1.
REQ-028 Reset assertion mid-slot or mid-commit SHALL take effect immediately without waiting for clk; first cycle after release starts BLANK of digit 0.

Configuration
REQ-029 With macro DISPLAY_SCAN_HEX_EN defined, values 10..15 SHALL decode to A,b,C,d,E,F = 8'h88, 83, C6, A1, 86, 8E (bit 7 from dp).
REQ-030 Without DISPLAY_SCAN_HEX_EN, values 10..15 SHALL decode to blank segments (bits 6:0 all 1), dp still honoured.

Verification (SHOW_CYC=4, BLANK_CYC=1)
REQ-031 Reset release, digit_en=8'hFF, no writes -> per digit 1 cycle an=FF/seg=FF then 4 cycles seg=C0, an=FE,FD,...,7F; frame_start every 40 cycles.
REQ-032 Write addr 3 data 7, commit mid-frame -> wr_ready low until wrap; digit 3 shows F8 only from the next frame; write attempted while wr_ready low is not applied.
REQ-033 Write and commit same cycle as final SHOW cycle of digit 7 -> active updated on the wrap edge, digit 0 of new frame uses new value.
REQ-034 digit_en=8'h01, dp_en=8'h01, active[0]=5 -> an=FE only in digit 0 SHOW with seg=12; all other slots an=FF; frame period still 40.
REQ-035 active[2]=4'hB -> seg=83 with DISPLAY_SCAN_HEX_EN, seg=FF without.
REQ-036 rst_n pulsed low during digit 5 SHOW after commit -> outputs FF immediately, buffers zero, pending cleared, scan restarts at digit 0.
